fc_layer_sequencer: RTL

- Compute-side controller attached to the wrapper side of GpAxisInterface (axisif_* signals).
- On axisif_start it sequences one shared signed multiply-accumulate datapath over the input buffer and an external weight memory, producing OUT_DATA_NUM fully-connected outputs.
- Writes each output into the interface's output buffer, then raises axisif_done so the interface streams the results out.

---
 rtl/gp_seq_pkg.sv | 23 ++
 rtl/fc_mac_unit.sv | 64 ++++++
 rtl/fc_layer_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/gp_seq_pkg.sv
// Shared definitions for the fully-connected layer sequencer.
// State encoding, address-width helper and accumulator sizing.
package gp_seq_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ISSUE  = 3'd1;
  localparam logic [2:0] DRAIN1 = 3'd2;
  localparam logic [2:0] DRAIN2 = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;

  // Never returns 0 so a single-entry buffer still gets a 1-bit address.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int acc_w(input int dw, input int n);
    return 2 * dw + clog2(n);
  endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// Operand stage, signed accumulator and output post-processing
// (arithmetic shift, optional ReLU, saturation) for one neuron.
module fc_mac_unit
  import gp_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int IN_DATA_NUM = 8,
  parameter int FRAC_BITS   = 0,
  parameter int RELU_EN     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  ld,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] w,
  output logic [DATA_WIDTH-1:0] y
);

  localparam int DW    = DATA_WIDTH;
  localparam int ACC_W = acc_w(DATA_WIDTH, IN_DATA_NUM);

  localparam logic signed [ACC_W-1:0] MAXV =
    {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

  logic signed [DW-1:0]    x_q;
  logic                    v1;
  logic signed [ACC_W-1:0] acc;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] sh;

  assign prod = (2*DW)'($signed(x_q)) * (2*DW)'($signed(w));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      v1  <= 1'b0;
      acc <= '0;
    end else begin
      v1 <= ld;
      if (ld)
        x_q <= x;
      // w arrives one cycle after its address, aligned with x_q
      if (clr)
        acc <= '0;
      else if (v1)
        acc <= acc + ACC_W'(prod);
    end
  end

  always_comb begin
    sh = acc >>> FRAC_BITS;
    if (RELU_EN != 0 && sh[ACC_W-1])
      sh = '0;
    if (sh > MAXV)
      y = MAXV[DW-1:0];
    else if (sh < MINV)
      y = MINV[DW-1:0];
    else
      y = sh[DW-1:0];
  end

endmodule

// File: rtl/fc_layer_sequencer.sv
// Sequences one shared MAC over the input buffer and weight memory,
// writing one output word per neuron, then signalling done.
module fc_layer_sequencer
  import gp_seq_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int IN_DATA_NUM  = 8,
  parameter int OUT_DATA_NUM = 4,
  parameter int FRAC_BITS    = 0,
  parameter int RELU_EN      = 0
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      axisif_start,
  output logic                                      axisif_done,
  output logic [clog2(IN_DATA_NUM)-1:0]             axisif_bufferIn_adr,
  input  logic [DATA_WIDTH-1:0]                     axisif_bufferIn_data,
  output logic [clog2(IN_DATA_NUM*OUT_DATA_NUM)-1:0] w_adr,
  input  logic [DATA_WIDTH-1:0]                     w_data,
  output logic [clog2(OUT_DATA_NUM)-1:0]            axisif_bufferOut_adr,
  output logic [DATA_WIDTH-1:0]                     axisif_bufferOut_data,
  output logic                                      axisif_bufferOut_wr
);

  localparam int IAW = clog2(IN_DATA_NUM);
  localparam int WAW = clog2(IN_DATA_NUM * OUT_DATA_NUM);
  localparam int OAW = clog2(OUT_DATA_NUM);

  localparam logic [IAW-1:0] I_LAST = IAW'(IN_DATA_NUM - 1);
  localparam logic [OAW-1:0] J_LAST = OAW'(OUT_DATA_NUM - 1);

  logic [2:0]            state, state_nx;
  logic                  start_q, trig;
  logic [OAW-1:0]        j;
  logic                  last_i, last_j;
  logic                  go, issue, load, nxt, fin;
  logic [DATA_WIDTH-1:0] post;

  assign trig   = axisif_start & ~start_q;
  assign last_i = (axisif_bufferIn_adr == I_LAST);
  assign last_j = (j == J_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (trig) state_nx = ISSUE;
      ISSUE:   if (last_i) state_nx = DRAIN1;
      DRAIN1:  state_nx = DRAIN2;
      DRAIN2:  state_nx = WRITE;
      WRITE:   state_nx = last_j ? IDLE : ISSUE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    go    = 1'b0;
    issue = 1'b0;
    load  = 1'b0;
    nxt   = 1'b0;
    fin   = 1'b0;
    unique case (state)
      IDLE:    go    = trig;
      ISSUE:   issue = 1'b1;
      DRAIN2:  load  = 1'b1;
      WRITE: begin
        nxt = ~last_j;
        fin = last_j;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q               <= 1'b0;
      j                     <= '0;
      axisif_done           <= 1'b1;
      axisif_bufferIn_adr   <= '0;
      w_adr                 <= '0;
      axisif_bufferOut_adr  <= '0;
      axisif_bufferOut_data <= '0;
      axisif_bufferOut_wr   <= 1'b0;
    end else begin
      start_q             <= axisif_start;
      axisif_bufferOut_wr <= load;
      if (go) begin
        j                   <= '0;
        axisif_bufferIn_adr <= '0;
        w_adr               <= '0;
        axisif_done         <= 1'b0;
      end
      if (issue && !last_i) begin
        axisif_bufferIn_adr <= axisif_bufferIn_adr + IAW'(1);
        w_adr               <= w_adr + WAW'(1);
      end
      // weight rows are contiguous, so row j+1 starts right after row j
      if (nxt) begin
        j                   <= j + OAW'(1);
        axisif_bufferIn_adr <= '0;
        w_adr               <= w_adr + WAW'(1);
      end
      if (fin)
        axisif_done <= 1'b1;
      if (load) begin
        axisif_bufferOut_adr  <= j;
        axisif_bufferOut_data <= post;
      end
    end
  end

  fc_mac_unit #(
    .DATA_WIDTH  (DATA_WIDTH),
    .IN_DATA_NUM (IN_DATA_NUM),
    .FRAC_BITS   (FRAC_BITS),
    .RELU_EN     (RELU_EN)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (go | nxt),
    .ld    (issue),
    .x     (axisif_bufferIn_data),
    .w     (w_data),
    .y     (post)
  );

endmodule
